pid_ctrl: RTL and testbench

- Closed-loop steering stage directly downstream of the IR error computation block.
- Consumes the signed 16-bit line-position error and its one-cycle valid strobe.
- Computes a saturating P + I + D correction and applies it symmetrically around a ramped forward speed.
- Produces registered 12-bit unsigned left/right motor speed commands for the PWM/motor drive stage.

---
 rtl/pid_pkg.sv | 25 ++
 rtl/pid_dterm.sv | 36 +++
 rtl/pid_ctrl.sv | 103 ++++++++++
 tb/tb_pid_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// pid_pkg: shared widths, error sample type and saturation helpers for the PID steering stage
package pid_pkg;

    localparam int ERR_SAT_W = 10;
    localparam int INTEG_W   = 15;
    localparam int DSAT_W    = 7;
    localparam int SPD_W     = 12;

    typedef logic signed [ERR_SAT_W-1:0] err_t;

    // Clamp a signed value into the range of a w-bit signed number (result still 16 bits wide)
    function automatic logic signed [15:0] sat_signed(input logic signed [15:0] v, input int w);
        logic signed [15:0] hi;
        logic signed [15:0] lo;
        hi = 16'((1 << (w - 1)) - 1);
        lo = 16'(-(1 << (w - 1)));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    // Clamp a 13-bit signed speed into the unsigned motor command range; negatives become 0
    function automatic logic [SPD_W-1:0] clip_unsigned(input logic signed [12:0] v);
        return (v < 13'sd0) ? '0 : (v > 13'sd4095) ? '1 : v[SPD_W-1:0];
    endfunction

endpackage

// File: rtl/pid_dterm.sv
// pid_dterm: derivative path - sample history queue, difference against oldest sample, saturation and gain
module pid_dterm
    import pid_pkg::*;
#(
    parameter int         DEPTH   = 12,
    parameter logic [5:0] D_COEFF = 6'h0B
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               upd,
    input  logic               clr,
    input  err_t               err_sat,
    output logic signed [12:0] d_term
);

    err_t                     q [DEPTH];
    logic signed [10:0]       d_diff;
    logic signed [DSAT_W-1:0] d_sat;

    assign d_diff = 11'(err_sat) - 11'(q[DEPTH-1]);
    assign d_sat  = DSAT_W'(sat_signed(16'(d_diff), DSAT_W));
    assign d_term = 13'(d_sat) * 13'($signed({1'b0, D_COEFF}));

    // Shift the newest error in on each update; go low empties the history back to zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (upd) begin
            q[0] <= err_sat;
            for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
        end
    end

endmodule

// File: rtl/pid_ctrl.sv
// pid_ctrl: P+I+D steering correction around a ramped forward speed; PID_ANTIWINDUP_EN freezes the integrator after an output clip
module pid_ctrl
    import pid_pkg::*;
#(
    parameter logic [3:0]  P_COEFF       = 4'h6,
    parameter logic [5:0]  D_COEFF       = 6'h0B,
    parameter int          D_QUEUE_DEPTH = 12,
    parameter logic [11:0] MAX_FRWRD     = 12'h2A0,
    parameter logic [11:0] RAMP_STEP     = 12'h004
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [15:0]      error,
    input  logic                    err_vld,
    input  logic                    go,
    output logic [SPD_W-1:0]        lft_spd,
    output logic [SPD_W-1:0]        rght_spd,
    output logic                    pid_vld
);

    logic                       upd;
    err_t                       err_sat;
    logic signed [13:0]         p_term;
    logic signed [INTEG_W-1:0]  integ;
    logic signed [INTEG_W-1:0]  integ_sum;
    logic                       integ_ovf;
    logic                       integ_hold;
    logic signed [8:0]          i_term;
    logic signed [12:0]         d_term;
    logic signed [14:0]         pid;
    logic signed [11:0]         corr;
    logic [12:0]                frwrd_sum;
    logic [SPD_W-1:0]           frwrd;
    logic [SPD_W-1:0]           frwrd_nxt;
    logic signed [12:0]         lft;
    logic signed [12:0]         rght;

    assign upd       = err_vld & go;
    assign err_sat   = ERR_SAT_W'(sat_signed(error, ERR_SAT_W));
    assign p_term    = 14'(err_sat) * 14'($signed({1'b0, P_COEFF}));
    assign integ_sum = integ + INTEG_W'(err_sat);
    assign integ_ovf = (integ[INTEG_W-1] == err_sat[ERR_SAT_W-1]) && (integ_sum[INTEG_W-1] != integ[INTEG_W-1]);
    assign i_term    = integ[14:6];
    assign pid       = 15'(p_term) + 15'(i_term) + 15'(d_term);
    assign corr      = 12'(pid >>> 3);
    assign frwrd_sum = 13'(frwrd) + 13'(RAMP_STEP);
    assign frwrd_nxt = (frwrd_sum > 13'(MAX_FRWRD)) ? MAX_FRWRD : frwrd_sum[SPD_W-1:0];
    assign lft       = $signed({1'b0, frwrd_nxt}) + 13'(corr);
    assign rght      = $signed({1'b0, frwrd_nxt}) - 13'(corr);

`ifdef PID_ANTIWINDUP_EN
    logic clip_flag;

    assign integ_hold = integ_ovf | clip_flag;

    // Remember whether the last update had to clip either motor command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clip_flag <= 1'b0;
        else if (!go) clip_flag <= 1'b0;
        else if (err_vld) clip_flag <= (lft < 13'sd0) || (rght < 13'sd0) || (lft > 13'sd4095) || (rght > 13'sd4095);
    end
`else
    assign integ_hold = integ_ovf;
`endif

    pid_dterm #(
        .DEPTH   (D_QUEUE_DEPTH),
        .D_COEFF (D_COEFF)
    ) u_dterm (
        .clk     (clk),
        .rst_n   (rst_n),
        .upd     (upd),
        .clr     (!go),
        .err_sat (err_sat),
        .d_term  (d_term)
    );

    // Advance integrator and ramp and register speeds on each update; go low parks everything at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ    <= '0;
            frwrd    <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            pid_vld  <= 1'b0;
        end else if (!go) begin
            integ    <= '0;
            frwrd    <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            pid_vld  <= 1'b0;
        end else begin
            pid_vld <= err_vld;
            if (err_vld) begin
                if (!integ_hold) integ <= integ_sum;
                frwrd    <= frwrd_nxt;
                lft_spd  <= clip_unsigned(lft);
                rght_spd <= clip_unsigned(rght);
            end
        end
    end

endmodule

// File: tb/tb_pid_ctrl.sv
// tb_pid_ctrl: directed vectors against an integer-arithmetic model of the PID steering stage
module tb_pid_ctrl;

    localparam int DQ   = 12;
    localparam int PK   = 6;
    localparam int DK   = 11;
    localparam int MAXF = 672;
    localparam int STEP = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] error = '0;
    logic               err_vld = 1'b0;
    logic               go = 1'b0;
    logic [11:0]        lft_spd;
    logic [11:0]        rght_spd;
    logic               pid_vld;

    int vectors = 0;
    int miscompares = 0;

    int m_integ = 0;
    int m_frwrd = 0;
    int m_hist [DQ];
    bit m_clip = 1'b0;
    int exp_l = 0;
    int exp_r = 0;
    bit exp_v = 1'b0;

    pid_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .error    (error),
        .err_vld  (err_vld),
        .go       (go),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .pid_vld  (pid_vld)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, $signed(act), $signed(exp));
        end
    endtask

    task automatic model_clear();
        m_integ = 0;
        m_frwrd = 0;
        m_clip  = 1'b0;
        for (int i = 0; i < DQ; i++) m_hist[i] = 0;
        exp_l = 0;
        exp_r = 0;
        exp_v = 1'b0;
    endtask

    task automatic model_step();
        int es, d, pidv, corr, l, r, s;
        bit hold;
        if (!rst_n || !go) begin
            model_clear();
        end else if (err_vld) begin
            es   = clamp(int'(error), -512, 511);
            d    = clamp(es - m_hist[DQ-1], -64, 63) * DK;
            pidv = es * PK + (m_integ >>> 6) + d;
            corr = pidv >>> 3;
            m_frwrd = (m_frwrd + STEP > MAXF) ? MAXF : m_frwrd + STEP;
            l = m_frwrd + corr;
            r = m_frwrd - corr;
            s = m_integ + es;
            hold = (s > 16383) || (s < -16384);
`ifdef PID_ANTIWINDUP_EN
            hold = hold || m_clip;
            m_clip = (l < 0) || (r < 0) || (l > 4095) || (r > 4095);
`endif
            if (!hold) m_integ = s;
            for (int i = DQ - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = es;
            exp_l = clamp(l, 0, 4095);
            exp_r = clamp(r, 0, 4095);
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
    endtask

    // Reference model advances on the same edges the design reacts to
    always @(posedge clk or negedge rst_n) model_step();

    // Every cycle, away from the active edge, the outputs must match the model
    always @(negedge clk) begin
        check("pid_vld", 32'(pid_vld), 32'(exp_v));
        check("lft_spd", 32'(lft_spd), 32'(exp_l));
        check("rght_spd", 32'(rght_spd), 32'(exp_r));
        check("integ", 32'(dut.integ), 32'(m_integ));
    end

    task automatic cyc(input logic signed [15:0] e, input logic v, input logic g);
        @(negedge clk);
        error   = e;
        err_vld = v;
        go      = g;
    endtask

    logic signed [15:0] pat [24] = '{16'sd100, -16'sd100, 16'sd300, -16'sd700, 16'sd5, 16'sd5, 16'sd5,
                                     -16'sd32768, 16'sd32767, 16'sd0, 16'sd64, -16'sd64, 16'sd511,
                                     -16'sd512, 16'sd20, 16'sd40, 16'sd60, -16'sd80, 16'sd1000,
                                     -16'sd3, 16'sd7, 16'sd250, -16'sd250, 16'sd0};

    initial begin
        for (int i = 0; i < DQ; i++) m_hist[i] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 1; k <= 10; k++) begin
            cyc(0, 1, 1);
            cyc(0, 0, 1);
            check("ramp_lft", 32'(lft_spd), 32'(4 * k));
            check("ramp_rght", 32'(rght_spd), 32'(4 * k));
            check("ramp_vld", 32'(pid_vld), 32'd1);
        end

        repeat (200) cyc(0, 1, 1);
        cyc(0, 0, 1);
        check("ramp_ceiling_lft", 32'(lft_spd), 32'd672);
        check("ramp_ceiling_rght", 32'(rght_spd), 32'd672);

        cyc(0, 0, 0);
        cyc(16'sh7FFF, 1, 1);
        cyc(0, 0, 1);
        check("maxerr_lft", 32'(lft_spd), 32'd473);
        check("maxerr_rght_clip", 32'(rght_spd), 32'd0);
        check("maxerr_vld", 32'(pid_vld), 32'd1);

        cyc(0, 0, 0);
        repeat (40) cyc(511, 1, 1);
        cyc(0, 0, 1);
`ifndef PID_ANTIWINDUP_EN
        check("integ_hold", 32'(dut.integ), 32'd16352);
`endif

        for (int i = 0; i < 24; i++) begin
            cyc(pat[i], 1, 1);
            if (i % 5 == 4) cyc(0, 0, 1);
        end
        cyc(0, 0, 1);

        cyc(200, 1, 1);
        cyc(200, 1, 0);
        cyc(0, 0, 1);
        check("godrop_lft", 32'(lft_spd), 32'd0);
        check("godrop_rght", 32'(rght_spd), 32'd0);
        check("godrop_vld", 32'(pid_vld), 32'd0);
        check("godrop_integ", 32'(dut.integ), 32'd0);
        for (int i = 0; i < DQ; i++) check("godrop_queue", 32'(dut.u_dterm.q[i]), 32'd0);

        repeat (5) cyc(50, 1, 1);
        cyc(0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_lft", 32'(lft_spd), 32'd0);
        check("async_rght", 32'(rght_spd), 32'd0);
        check("async_vld", 32'(pid_vld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 1);
        cyc(0, 0, 1);
        check("restart_lft", 32'(lft_spd), 32'd4);
        check("restart_rght", 32'(rght_spd), 32'd4);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
